// File: rtl/zero_pred_seq_pkg.sv
// zero_pred_seq_pkg
//   Shared constants and types for the G.726 zero-predictor sequencer:
//   tap count and widths, the delay-line reset value, FSM state encoding
//   and ADPCM rate codes.
package zero_pred_seq_pkg;

    localparam int NTAPS = 6;           // zero-predictor taps, indexed 1..NTAPS
    localparam int DQF_W = 11;          // floating-point DQn width
    localparam int B_W   = 16;          // Bn / WBn width
    localparam int TAP_W = 3;           // tap index width (0 = no tap)

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NTAPS);

    // Delay-line reset value: FLOATA representation of +0 with exponent 0, mantissa 32.
    localparam logic [DQF_W-1:0] DQ_RST = 11'h020;

    localparam logic TAP_MODE_PRED = 1'b0;
    localparam logic TAP_MODE_UPD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UPD   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_PRED  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RATE_40K = 2'd0,
        RATE_32K = 2'd1,
        RATE_24K = 2'd2,
        RATE_16K = 2'd3
    } rate_t;

endpackage

// File: rtl/zero_pred_seq_if.sv
// zero_pred_seq_if
//   Bundles the sample request/response signals and the shared tap-unit
//   port of the zero-predictor sequencer.
//   slave  : the sequencer (consumes start/sample, drives busy/done/sez and tap_*)
//   master : the surrounding codec datapath (drives sample and tap-unit results)
interface zero_pred_seq_if;
    import zero_pred_seq_pkg::*;

    // sample request / response
    logic               start;
    logic [1:0]         rate;
    logic [15:0]        dq;
    logic [DQF_W-1:0]   dq_f;
    logic               tr;
    logic               busy;
    logic               done;
    logic [14:0]        sez;

    // shared tap unit
    logic               tap_mode;
    logic [TAP_W-1:0]   tap_sel;
    logic [DQF_W-1:0]   tap_dqn;
    logic [B_W-1:0]     tap_bn;
    logic [15:0]        tap_dq;
    logic               tap_tr;
    logic [1:0]         tap_rate;
    logic [B_W-1:0]     tap_bnew;
    logic [B_W-1:0]     tap_wb;

    modport slave (
        input  start, rate, dq, dq_f, tr, tap_bnew, tap_wb,
        output busy, done, sez,
        output tap_mode, tap_sel, tap_dqn, tap_bn, tap_dq, tap_tr, tap_rate
    );

    modport master (
        output start, rate, dq, dq_f, tr, tap_bnew, tap_wb,
        input  busy, done, sez,
        input  tap_mode, tap_sel, tap_dqn, tap_bn, tap_dq, tap_tr, tap_rate
    );

endinterface

// File: rtl/zero_pred_seq_tap_bank.sv
// zp_tap_bank
//   DQ1..DQn float delay line and B1..Bn coefficient bank.
//   clk, reset   : clock, asynchronous active-high clear (B=0, DQ=DQ_RST)
//   rd_sel       : tap index 1..NTAPS for the read port (0 reads zero)
//   rd_dqn/rd_bn : combinational read of the selected tap
//   b_we/b_wsel/b_wdata : coefficient write port
//   shift_en/shift_din  : shift DQ1..DQn-1 into DQ2..DQn, load DQ1
module zp_tap_bank
    import zero_pred_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [TAP_W-1:0]   rd_sel,
    output logic [DQF_W-1:0]   rd_dqn,
    output logic [B_W-1:0]     rd_bn,
    input  logic               b_we,
    input  logic [TAP_W-1:0]   b_wsel,
    input  logic [B_W-1:0]     b_wdata,
    input  logic               shift_en,
    input  logic [DQF_W-1:0]   shift_din
);

    // element 0 holds tap 1
    logic [DQF_W-1:0] dq_all [NTAPS];
    logic [B_W-1:0]   b_all  [NTAPS];

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
            logic [DQF_W-1:0] dq_reg;
            logic [DQF_W-1:0] dq_next;
            logic [B_W-1:0]   b_reg;

            if (gi == 0) begin : g_head
                assign dq_next = shift_din;
            end else begin : g_body
                assign dq_next = dq_all[gi-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dq_reg <= DQ_RST;
                    b_reg  <= '0;
                end else begin
                    if (shift_en)
                        dq_reg <= dq_next;
                    if (b_we && (b_wsel == TAP_W'(gi + 1)))
                        b_reg <= b_wdata;
                end
            end

            assign dq_all[gi] = dq_reg;
            assign b_all[gi]  = b_reg;
        end
    endgenerate

    always_comb begin
        rd_dqn = '0;
        rd_bn  = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (rd_sel == TAP_W'(i + 1)) begin
                rd_dqn = dq_all[i];
                rd_bn  = b_all[i];
            end
        end
    end

endmodule

// File: rtl/zero_pred_seq.sv
// zero_pred_seq
//   Time-multiplexes one shared zero-predictor tap unit over the six taps.
//   Per sample: UPD (6 cycles, Bn <= tap_bnew using pre-shift DQn),
//   SHIFT (1 cycle, new DQ enters DQ1), PRED (6 cycles, accumulate WBn
//   with post-shift DQn and updated Bn), DONE (1 cycle, done pulse).
//   clk   : clock
//   reset : asynchronous active-high; clears all state, no done issued
//   bus   : sample request (start/rate/dq/dq_f/tr), busy/done/sez,
//           and the shared tap-unit port (tap_*)
module zero_pred_seq
    import zero_pred_seq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    zero_pred_seq_if.slave  bus
);

    state_t             state_reg, state_next;
    logic [TAP_W-1:0]   tap_reg, tap_next;

    logic [1:0]         rate_reg;
    logic [15:0]        dq_reg;
    logic [DQF_W-1:0]   dqf_reg;
    logic               tr_reg;
    logic [15:0]        acc_reg;
    logic [14:0]        sez_reg;

    logic               b_we;
    logic               shift_en;
    logic               accept;
    logic               pred_last;
    logic [15:0]        acc_sum;

    // SEZI wraps modulo 2^16; no saturation.
    assign acc_sum   = acc_reg + bus.tap_wb;
    assign accept    = (state_reg == ST_IDLE) && bus.start;
    assign pred_last = (state_reg == ST_PRED) && (tap_reg == TAP_LAST);

    always_comb begin
        state_next   = state_reg;
        tap_next     = tap_reg;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.tap_mode = TAP_MODE_PRED;
        bus.tap_tr   = 1'b0;
        b_we         = 1'b0;
        shift_en     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_UPD;
                    tap_next   = TAP_W'(1);
                end
            end
            ST_UPD: begin
                bus.busy     = 1'b1;
                bus.tap_mode = TAP_MODE_UPD;
                bus.tap_tr   = tr_reg;
                b_we         = 1'b1;
                if (tap_reg == TAP_LAST) begin
                    state_next = ST_SHIFT;
                    tap_next   = '0;
                end else begin
                    tap_next = tap_reg + TAP_W'(1);
                end
            end
            ST_SHIFT: begin
                bus.busy   = 1'b1;
                shift_en   = 1'b1;
                state_next = ST_PRED;
                tap_next   = TAP_W'(1);
            end
            ST_PRED: begin
                bus.busy = 1'b1;
                if (tap_reg == TAP_LAST) begin
                    state_next = ST_DONE;
                    tap_next   = '0;
                end else begin
                    tap_next = tap_reg + TAP_W'(1);
                end
            end
            ST_DONE: begin
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                tap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            tap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
        end
    end

    // Sample latches load only when a start is accepted; later starts and
    // input changes leave the in-flight sample untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_reg <= '0;
            dq_reg   <= '0;
            dqf_reg  <= '0;
            tr_reg   <= 1'b0;
        end else if (accept) begin
            rate_reg <= bus.rate;
            dq_reg   <= bus.dq;
            dqf_reg  <= bus.dq_f;
            tr_reg   <= bus.tr;
        end
    end

    // sez is loaded with the final sum as PRED ends so it is already valid
    // while done is high, and it holds until the next sample completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
            sez_reg <= '0;
        end else begin
            if (state_reg == ST_SHIFT)
                acc_reg <= '0;
            else if (state_reg == ST_PRED)
                acc_reg <= acc_sum;
            if (pred_last)
                sez_reg <= acc_sum[15:1];
        end
    end

    zp_tap_bank u_bank (
        .clk       (clk),
        .reset     (reset),
        .rd_sel    (tap_reg),
        .rd_dqn    (bus.tap_dqn),
        .rd_bn     (bus.tap_bn),
        .b_we      (b_we),
        .b_wsel    (tap_reg),
        .b_wdata   (bus.tap_bnew),
        .shift_en  (shift_en),
        .shift_din (dqf_reg)
    );

    assign bus.sez      = sez_reg;
    assign bus.tap_sel  = tap_reg;
    assign bus.tap_dq   = dq_reg;
    assign bus.tap_rate = rate_reg;

endmodule

// File: tb/tb_zero_pred_seq.sv
// tb_zero_pred_seq
//   Randomized bench for zero_pred_seq. A stand-in shared tap unit computes
//   tap_bnew/tap_wb; a sample-level reference (coefficient array, delay-line
//   array, plain sum) predicts every tap presentation and sez.
module tb_zero_pred_seq;
    import zero_pred_seq_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   unit_mode;   // 0: bnew = tr ? 0 : bn+0x10 ; 1: bnew = 0x7FFF

    zero_pred_seq_if zif ();

    zero_pred_seq dut (
        .clk   (clk),
        .reset (rst),
        .bus   (zif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] unit_bnew(input logic [15:0] b, input logic t, input int mode);
        if (mode == 1) return 16'h7FFF;
        return t ? 16'h0000 : b + 16'h0010;
    endfunction

    // stand-in for the shared UPB/TRIGB/FMULT unit
    always_comb begin
        zif.tap_bnew = unit_bnew(zif.tap_bn, zif.tap_tr, unit_mode);
        zif.tap_wb   = zif.tap_bn;
    end

    // reference state, indexed by tap number
    logic [15:0] b_m  [1:6];
    logic [10:0] dq_m [1:6];
    logic [14:0] sez_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 6; i++) begin
            b_m[i]  = 16'h0000;
            dq_m[i] = 11'h020;
        end
        sez_m = 15'h0000;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(zif.busy),     32'd0);
        check({tag, "_done"},    32'(zif.done),     32'd0);
        check({tag, "_sez"},     32'(zif.sez),      32'(sez_m));
        check({tag, "_tap_sel"}, 32'(zif.tap_sel),  32'd0);
        check({tag, "_tap_tr"},  32'(zif.tap_tr),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One sample. repulse_at: cycle in which start is pulsed again (0 = never).
    // reset_at: cycle in which reset is pulsed (0 = never); the sample is abandoned.
    task automatic run_sample(input logic [10:0] f, input logic t, input logic [1:0] r,
                              input logic [15:0] d, input int repulse_at, input int reset_at);
        logic [15:0] b_pre   [1:6];
        logic [15:0] b_new   [1:6];
        logic [10:0] dq_pre  [1:6];
        logic [10:0] dq_post [1:6];
        logic [15:0] sezi;
        logic [14:0] sez_exp;

        sezi = 16'h0000;
        for (int i = 1; i <= 6; i++) begin
            b_pre[i]  = b_m[i];
            dq_pre[i] = dq_m[i];
            b_new[i]  = unit_bnew(b_m[i], t, unit_mode);
            sezi      = sezi + b_new[i];
        end
        dq_post[1] = f;
        for (int i = 2; i <= 6; i++) dq_post[i] = dq_pre[i-1];
        sez_exp = sezi[15:1];

        @(negedge clk);
        zif.start = 1'b1;
        zif.dq_f  = f;
        zif.tr    = t;
        zif.rate  = r;
        zif.dq    = d;
        @(negedge clk);
        // cycle 1; scramble the inputs, they must be ignored from here on
        zif.start = 1'b0;
        zif.dq_f  = 11'($urandom);
        zif.tr    = 1'($urandom);
        zif.rate  = 2'($urandom);
        zif.dq    = 16'($urandom);

        for (int c = 1; c <= 14; c++) begin
            if (c == reset_at) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("arst_busy",    32'(zif.busy),     32'd0);
                check("arst_sez",     32'(zif.sez),      32'd0);
                check("arst_tap_sel", 32'(zif.tap_sel),  32'd0);
                check("arst_mode",    32'(zif.tap_mode), 32'd0);
                check("arst_done",    32'(zif.done),     32'd0);
                #2;
                rst = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    check("arst_no_done", 32'(zif.done), 32'd0);
                end
                check_idle_outputs("arst_idle");
                $display("sample dq_f=%0h tr=%0d aborted by reset at cycle %0d", f, t, c);
                return;
            end

            if (c == repulse_at) begin
                zif.start = 1'b1;
                zif.dq_f  = ~f;
                zif.tr    = ~t;
            end else begin
                zif.start = 1'b0;
            end

            check("busy", 32'(zif.busy), 32'(c < 14));
            check("done", 32'(zif.done), 32'(c == 14));
            if (c == 1) begin
                check("tap_dq",   32'(zif.tap_dq),   32'(d));
                check("tap_rate", 32'(zif.tap_rate), 32'(r));
            end
            if (c <= 6) begin
                check("upd_sel",  32'(zif.tap_sel),  32'(c));
                check("upd_mode", 32'(zif.tap_mode), 32'd1);
                check("upd_tr",   32'(zif.tap_tr),   32'(t));
                check("upd_dqn",  32'(zif.tap_dqn),  32'(dq_pre[c]));
                check("upd_bn",   32'(zif.tap_bn),   32'(b_pre[c]));
            end else if (c == 7) begin
                check("shift_sel", 32'(zif.tap_sel), 32'd0);
                check("shift_tr",  32'(zif.tap_tr),  32'd0);
            end else if (c <= 13) begin
                check("pred_sel",  32'(zif.tap_sel),  32'(c - 7));
                check("pred_mode", 32'(zif.tap_mode), 32'd0);
                check("pred_tr",   32'(zif.tap_tr),   32'd0);
                check("pred_dqn",  32'(zif.tap_dqn),  32'(dq_post[c-7]));
                check("pred_bn",   32'(zif.tap_bn),   32'(b_new[c-7]));
                if (c == 13) check("sez_held", 32'(zif.sez), 32'(sez_m));
            end else begin
                check("done_sez", 32'(zif.sez),     32'(sez_exp));
                check("done_sel", 32'(zif.tap_sel), 32'd0);
            end
            @(negedge clk);
        end

        for (int i = 1; i <= 6; i++) begin
            b_m[i]  = b_new[i];
            dq_m[i] = dq_post[i];
        end
        sez_m = sez_exp;
        // cycle 15: back in idle, single done, sez held
        check_idle_outputs("after_done");
        $display("sample dq_f=%0h tr=%0d rate=%0d sez=%0h exp=%0h", f, t, r, zif.sez, sez_exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        unit_mode = 0;
        rst       = 1'b1;
        zif.start = 1'b0;
        zif.rate  = 2'd0;
        zif.dq    = 16'h0000;
        zif.dq_f  = 11'h000;
        zif.tr    = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_mode", 32'(zif.tap_mode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // 1: dq_f=0 from reset state, taps 2..6 show the reset delay line
        run_sample(11'h000, 1'b0, 2'd1, 16'h1234, 0, 0);

        // 2: first sample after reset with dq_f=0x040
        do_reset();
        run_sample(11'h040, 1'b0, 2'd0, 16'h0042, 0, 0);
        check("t2_sez", 32'(zif.sez), 32'h30);

        // 3: start re-pulsed at cycle 5 is ignored
        run_sample(11'($urandom), 1'b0, 2'($urandom), 16'($urandom), 5, 0);

        // 4: tr=1 clears the coefficients through the unit
        run_sample(11'($urandom), 1'b1, 2'($urandom), 16'($urandom), 0, 0);
        check("t4_sez", 32'(zif.sez), 32'h0);

        // 5: bank forced to 0x7FFF, sum wraps
        unit_mode = 1;
        run_sample(11'($urandom), 1'b0, 2'($urandom), 16'($urandom), 0, 0);
        unit_mode = 0;
        check("t5_sez", 32'(zif.sez), 32'h7FFD);

        // 6: seven samples 1..7 walk through the delay line
        do_reset();
        for (int k = 1; k <= 7; k++)
            run_sample(11'(k), 1'b0, 2'(k), 16'(k), 0, 0);

        // 7: reset mid-operation, then a clean sample
        run_sample(11'($urandom), 1'b0, 2'($urandom), 16'($urandom), 0, 9);
        run_sample(11'($urandom), 1'b0, 2'($urandom), 16'($urandom), 0, 0);

        // random samples
        for (int k = 0; k < 10; k++)
            run_sample(11'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                       16'($urandom), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
